// File: rtl/score_disp_pkg.sv
// Shared encodings and segment patterns for the score display.
package score_disp_pkg;

    localparam logic [1:0] ST_RESET = 2'd0;
    localparam logic [1:0] ST_PLAY  = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_OVER  = 2'd3;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Active-low {g,f,e,d,c,b,a} patterns; element k holds the pattern for digit k.
    localparam logic [9:0][6:0] DIGIT_SEG = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low seven-segment decoder with blanking.
module bcd_to_seg7
    import score_disp_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    // Blank wins; non-BCD nibbles show a dash.
    always_comb begin
        seg = SEG_DASH;
        if (blank) begin
            seg = SEG_BLANK;
        end else if (nibble <= 4'd9) begin
            seg = DIGIT_SEG[nibble];
        end
    end

endmodule

// File: rtl/score_display.sv
// Four-digit multiplexed common-anode display driver for the packed-BCD score.
module score_display
    import score_disp_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  state,
    input  logic [15:0] score,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    localparam int unsigned REF_W   = $clog2(REFRESH_DIV);
    localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [REF_W-1:0]   refresh_cnt_q, refresh_cnt_d;
    logic [1:0]         digit_idx_q, digit_idx_d;
    logic [15:0]        shadow_q, shadow_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;   // 1 = hidden
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;
    logic [3:0]         an_q, an_d;

    logic               slot_end;
    logic               frame_end;
    logic [3:0]         cur_nibble;
    logic               cur_blank;
    logic [6:0]         dec_seg;

    // Select the scanned nibble and its leading-zero blanking condition.
    always_comb begin
        cur_nibble = shadow_q[3:0];
        cur_blank  = 1'b0;
        case (digit_idx_q)
            2'd1: begin
                cur_nibble = shadow_q[7:4];
                cur_blank  = (shadow_q[15:4] == 12'h000);
            end
            2'd2: begin
                cur_nibble = shadow_q[11:8];
                cur_blank  = (shadow_q[15:8] == 8'h00);
            end
            2'd3: begin
                cur_nibble = shadow_q[15:12];
                cur_blank  = (shadow_q[15:12] == 4'h0);
            end
            default: begin
                cur_nibble = shadow_q[3:0];
                cur_blank  = 1'b0;
            end
        endcase
    end

    bcd_to_seg7 u_dec (
        .nibble (cur_nibble),
        .blank  (cur_blank),
        .seg    (dec_seg)
    );

    // Scan counters, frame-synchronous score latch, blink timing and output decode.
    always_comb begin
        slot_end      = (refresh_cnt_q == REF_W'(REFRESH_DIV - 1));
        frame_end     = slot_end && (digit_idx_q == 2'd3);

        refresh_cnt_d = slot_end ? '0 : refresh_cnt_q + REF_W'(1);
        digit_idx_d   = slot_end ? digit_idx_q + 2'd1 : digit_idx_q;
        shadow_d      = frame_end ? score : shadow_q;

        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (state != ST_OVER) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else if (frame_end) begin
            if (blink_cnt_q == BLINK_W'(BLINK_FRAMES - 1)) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d   = blink_cnt_q + BLINK_W'(1);
            end
        end

        seg_d = SEG_BLANK;
        an_d  = 4'hF;
        dp_d  = 1'b1;
        if (!blink_phase_q) begin
            seg_d = dec_seg;
            an_d  = ~(4'b0001 << digit_idx_q);
            dp_d  = !((state == ST_PAUSE) && (digit_idx_q == 2'd0));
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt_q <= '0;
            digit_idx_q   <= 2'd0;
            shadow_q      <= 16'h0000;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            seg_q         <= SEG_BLANK;
            dp_q          <= 1'b1;
            an_q          <= 4'hF;
        end else begin
            refresh_cnt_q <= refresh_cnt_d;
            digit_idx_q   <= digit_idx_d;
            shadow_q      <= shadow_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            an_q          <= an_d;
        end
    end

    assign seg = seg_q;
    assign dp  = dp_q;
    assign an  = an_q;

endmodule

// File: tb/tb_score_display.sv
// Directed self-checking bench for score_display with a short refresh and blink period.
module tb_score_display;

    logic        clk;
    logic        rst_n;
    logic [1:0]  state;
    logic [15:0] score;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    int checks;
    int errors;

    score_display #(
        .REFRESH_DIV  (4),
        .BLINK_FRAMES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .state (state),
        .score (score),
        .seg   (seg),
        .dp    (dp),
        .an    (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance n rising edges, then park on the falling edge for sampling/driving.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_slot(input string tag, input logic [3:0] exp_an,
                              input logic [6:0] exp_seg, input logic exp_dp);
        check_eq({tag, ".an"},  16'(an),  16'(exp_an));
        check_eq({tag, ".seg"}, 16'(seg), 16'(exp_seg));
        check_eq({tag, ".dp"},  16'(dp),  16'(exp_dp));
    endtask

    // Called on the first output cycle of a frame; returns on the first cycle of the next.
    task automatic check_frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                               input logic [6:0] s2, input logic [6:0] s3,
                               input logic hidden, input logic pause);
        logic [6:0] exp_seg [4];
        logic [3:0] exp_an;
        logic       exp_dp;
        exp_seg[0] = s0; exp_seg[1] = s1; exp_seg[2] = s2; exp_seg[3] = s3;
        for (int d = 0; d < 4; d++) begin
            exp_an = ~(4'b0001 << d);
            exp_dp = !(pause && d == 0);
            if (hidden) check_slot($sformatf("%s.d%0d", tag, d), 4'hF, 7'h7F, 1'b1);
            else        check_slot($sformatf("%s.d%0d", tag, d), exp_an, exp_seg[d], exp_dp);
            tick(4);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        state  = 2'd1;
        score  = 16'h0000;

        // 1: reset values, then first scan with zero score
        repeat (3) @(negedge clk);
        check_slot("reset", 4'hF, 7'h7F, 1'b1);
        rst_n = 1'b1;
        tick(1);
        check_frame("zero_f0", 7'h40, 7'h7F, 7'h7F, 7'h7F, 1'b0, 1'b0);

        // 2: 1234 latched at end of current frame
        score = 16'h1234;
        tick(16);
        check_frame("s1234_a", 7'h19, 7'h30, 7'h24, 7'h79, 1'b0, 1'b0);
        check_frame("s1234_b", 7'h19, 7'h30, 7'h24, 7'h79, 1'b0, 1'b0);

        // 3: leading-zero blanking and dash for non-BCD
        score = 16'h0050;
        tick(16);
        check_frame("s0050", 7'h40, 7'h12, 7'h7F, 7'h7F, 1'b0, 1'b0);
        score = 16'h00A0;
        tick(16);
        check_frame("s00A0", 7'h40, 7'h3F, 7'h7F, 7'h7F, 1'b0, 1'b0);

        // 4: mid-frame score change is deferred to the next frame
        score = 16'h1111;
        tick(16);
        check_frame("s1111", 7'h79, 7'h79, 7'h79, 7'h79, 1'b0, 1'b0);
        tick(5);
        score = 16'h2222;
        check_slot("mid_d1", 4'hD, 7'h79, 1'b1);
        tick(3);
        check_slot("mid_d2", 4'hB, 7'h79, 1'b1);
        tick(4);
        check_slot("mid_d3", 4'h7, 7'h79, 1'b1);
        tick(4);
        check_frame("s2222", 7'h24, 7'h24, 7'h24, 7'h24, 1'b0, 1'b0);

        // 5: game-over blinking, 2 frames visible / 2 hidden
        state = 2'd3;
        check_frame("blink_v0", 7'h24, 7'h24, 7'h24, 7'h24, 1'b0, 1'b0);
        check_frame("blink_v1", 7'h24, 7'h24, 7'h24, 7'h24, 1'b0, 1'b0);
        check_frame("blink_h0", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 1'b1, 1'b0);
        check_frame("blink_h1", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 1'b1, 1'b0);
        check_frame("blink_v2", 7'h24, 7'h24, 7'h24, 7'h24, 1'b0, 1'b0);
        check_frame("blink_v3", 7'h24, 7'h24, 7'h24, 7'h24, 1'b0, 1'b0);
        tick(1);
        check_slot("hid_pre", 4'hF, 7'h7F, 1'b1);
        state = 2'd1;
        tick(2);
        check_slot("resume", 4'hE, 7'h24, 1'b1);
        tick(13);

        // pause marker on digit 0 only
        state = 2'd2;
        tick(16);
        check_frame("pause", 7'h24, 7'h24, 7'h24, 7'h24, 1'b0, 1'b1);
        state = 2'd1;

        // 6: async reset mid-frame during digit-2 slot
        score = 16'h9999;
        tick(16);
        check_frame("s9999", 7'h10, 7'h10, 7'h10, 7'h10, 1'b0, 1'b0);
        tick(8);
        check_slot("pre_rst", 4'hB, 7'h10, 1'b1);
        tick(1);
        #2;
        rst_n = 1'b0;
        #1;
        check_slot("async_rst", 4'hF, 7'h7F, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        check_frame("post_rst", 7'h40, 7'h7F, 7'h7F, 7'h7F, 1'b0, 1'b0);
        check_frame("post_rst_l", 7'h10, 7'h10, 7'h10, 7'h10, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
